// File: rtl/nf5_mem_pkg.sv
// ---------------------------------------------------------------------------
// nf5_mem_pkg
// Shared definitions for the three-port memory arbiter:
//   - 2-bit port identifiers used for arbitration results and grant_id
//   - FSM state encoding for the arbiter sequencer
//   - default aging threshold for the instruction-fetch port
// ---------------------------------------------------------------------------
package nf5_mem_pkg;

  // Requester identifiers. PORT_NONE doubles as "no owner" on grant_id.
  localparam logic [1:0] PORT_LD   = 2'd0;
  localparam logic [1:0] PORT_LSU  = 2'd1;
  localparam logic [1:0] PORT_IF   = 2'd2;
  localparam logic [1:0] PORT_NONE = 2'd3;

  // Number of lost arbitrations after which instruction fetch outranks the LSU.
  localparam int AGE_LIMIT_DEF = 3;

  // One access occupies IDLE (arbitrate) -> ISSUE (mem_en) -> WAIT (ack).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// One requester port of the memory arbiter.
//   req    requester -> arbiter  access request, held until ack
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  byte address (low bits passed through)
//   wdata  requester -> arbiter  write data
//   wstrb  requester -> arbiter  byte enables (writes only)
//   ack    arbiter -> requester  one-cycle completion pulse
//   rdata  arbiter -> requester  read data, meaningful only while ack = 1
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if
  import nf5_mem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection for the memory arbiter.
//   ld_req_i   in  program loader request
//   lsu_req_i  in  load/store unit request
//   if_req_i   in  instruction fetch request
//   age_cnt_i  in  number of arbitrations instruction fetch has lost
//   win_o      out winning port ID (PORT_NONE when nobody requests)
// Priority: loader always first; then instruction fetch if it has aged to
// AGE_LIMIT; otherwise LSU ahead of instruction fetch.
// ---------------------------------------------------------------------------
module mem_arb_pick
  import nf5_mem_pkg::*;
#(
  parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic       ld_req_i,
  input  logic       lsu_req_i,
  input  logic       if_req_i,
  input  logic [1:0] age_cnt_i,
  output logic [1:0] win_o
);

  localparam logic [1:0] AGE_MAX = 2'(AGE_LIMIT);

  always_comb begin
    win_o = PORT_NONE;
    if (ld_req_i) begin
      win_o = PORT_LD;
    end else if (if_req_i && (age_cnt_i >= AGE_MAX)) begin
      // Starvation guard: fetch has waited long enough to jump the LSU.
      win_o = PORT_IF;
    end else if (lsu_req_i) begin
      win_o = PORT_LSU;
    end else if (if_req_i) begin
      win_o = PORT_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Three-port arbiter in front of a single-ported synchronous memory.
// Each access takes three cycles: IDLE (arbitrate, capture payload),
// ISSUE (mem_en strobe), WAIT (memory returns data, winner gets ack).
//
// Ports
//   clk        in   clock, all state on rising edge
//   rst        in   synchronous active-high reset
//   ld_port    slave  program loader requester
//   lsu_port   slave  load/store unit requester
//   if_port    slave  instruction fetch requester
//   mem_en     out  memory access strobe (ISSUE only)
//   mem_we     out  memory write enable
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_wstrb  out  memory byte enables
//   mem_rdata  in   memory read data, valid the cycle after mem_en
//   busy       out  high in ISSUE and WAIT
//   grant_id   out  current owner (PORT_NONE in IDLE)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import nf5_mem_pkg::*;
#(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  ld_port,
  mem_port_arbiter_if.slave  lsu_port,
  mem_port_arbiter_if.slave  if_port,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  output logic [3:0]         mem_wstrb,
  input  logic [DW-1:0]      mem_rdata,
  output logic               busy,
  output logic [1:0]         grant_id
);

  localparam logic [1:0] AGE_MAX = 2'(AGE_LIMIT);

  // Saturating increment of the fetch aging counter.
  function automatic logic [1:0] age_sat_inc(input logic [1:0] a);
    if (a >= AGE_MAX) begin
      return AGE_MAX;
    end
    return a + 2'd1;
  endfunction

  arb_state_e    state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    age_q,   age_d;
  logic          we_q,    we_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;

  logic [1:0]    win;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          ack_phase;

  mem_arb_pick #(
    .AGE_LIMIT (AGE_LIMIT)
  ) u_pick (
    .ld_req_i  (ld_port.req),
    .lsu_req_i (lsu_port.req),
    .if_req_i  (if_port.req),
    .age_cnt_i (age_q),
    .win_o     (win)
  );

  // Payload of whichever port is currently winning arbitration.
  always_comb begin
    sel_we    = if_port.we;
    sel_addr  = if_port.addr;
    sel_wdata = if_port.wdata;
    sel_wstrb = if_port.wstrb;
    case (win)
      PORT_LD: begin
        sel_we    = ld_port.we;
        sel_addr  = ld_port.addr;
        sel_wdata = ld_port.wdata;
        sel_wstrb = ld_port.wstrb;
      end
      PORT_LSU: begin
        sel_we    = lsu_port.we;
        sel_addr  = lsu_port.addr;
        sel_wdata = lsu_port.wdata;
        sel_wstrb = lsu_port.wstrb;
      end
      default: ;
    endcase
  end

  // Next-state logic. Requests and payloads are only looked at in IDLE, so
  // anything a requester does while it owns the memory has no effect.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    age_d   = age_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;

    case (state_q)
      ST_IDLE: begin
        if (win != PORT_NONE) begin
          state_d = ST_ISSUE;
          owner_d = win;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          wstrb_d = sel_wstrb;
        end
        // Fetch ages on every loss, including losses to the loader.
        if (win == PORT_IF) begin
          age_d = 2'd0;
        end else if (if_port.req) begin
          age_d = age_sat_inc(age_q);
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        owner_d = PORT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = PORT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_NONE;
      age_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      age_q   <= age_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  // Outputs are gated by rst directly so the reset values appear in the very
  // cycle rst is high, which also cancels an ack that would land in WAIT.
  assign ack_phase = !rst && (state_q == ST_WAIT);

  assign busy      = !rst && (state_q != ST_IDLE);
  assign mem_en    = !rst && (state_q == ST_ISSUE);
  assign mem_we    = rst ? 1'b0 : we_q;
  assign mem_addr  = rst ? '0   : addr_q;
  assign mem_wdata = rst ? '0   : wdata_q;
  assign mem_wstrb = rst ? 4'd0 : wstrb_q;
  assign grant_id  = (rst || (state_q == ST_IDLE)) ? PORT_NONE : owner_q;

  assign ld_port.ack  = ack_phase && (owner_q == PORT_LD);
  assign lsu_port.ack = ack_phase && (owner_q == PORT_LSU);
  assign if_port.ack  = ack_phase && (owner_q == PORT_IF);

  // Memory data is forwarded to every port; only the acked one may use it.
  assign ld_port.rdata  = mem_rdata;
  assign lsu_port.rdata = mem_rdata;
  assign if_port.rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import nf5_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AGE_LIMIT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [3:0]    mem_wstrb;
  logic [1:0]    grant_id;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) ld_if ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) lsu_if ();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) if_if ();

  // Requester drive state, index 0=ld 1=lsu 2=if
  logic        rq  [3];
  logic        twe [3];
  logic [31:0] tad [3];
  logic [31:0] twd [3];
  logic [3:0]  tst [3];

  assign ld_if.req    = rq[0];  assign ld_if.we    = twe[0];
  assign ld_if.addr   = tad[0]; assign ld_if.wdata = twd[0]; assign ld_if.wstrb = tst[0];
  assign lsu_if.req   = rq[1];  assign lsu_if.we   = twe[1];
  assign lsu_if.addr  = tad[1]; assign lsu_if.wdata = twd[1]; assign lsu_if.wstrb = tst[1];
  assign if_if.req    = rq[2];  assign if_if.we    = twe[2];
  assign if_if.addr   = tad[2]; assign if_if.wdata = twd[2]; assign if_if.wstrb = tst[2];

  logic [2:0]  ack_v;
  logic [31:0] rdv [3];
  assign ack_v  = {if_if.ack, lsu_if.ack, ld_if.ack};
  assign rdv[0] = ld_if.rdata;
  assign rdv[1] = lsu_if.rdata;
  assign rdv[2] = if_if.rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .AGE_LIMIT(AGE_LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_port   (ld_if),
    .lsu_port  (lsu_if),
    .if_port   (if_if),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  typedef struct {
    int          cyc;
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  exp_t       mem_q[$];
  exp_t       ack_q[$];
  logic [1:0] gseq[$];
  int         lsu_ack_cyc[$];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rand_mode = 1'b0;
  bit   hold [3];
  bit   ack_last [3];

  // Reference model state
  int next_arb = 0;
  int age = 0;
  int own_p = -1;
  int own_arb = -10;

  logic        last_we;
  logic [31:0] last_addr, last_wd;
  logic [3:0]  last_st;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
  endtask

  task automatic new_payload(input int p);
    twe[p] = 1'($urandom_range(1, 0));
    tad[p] = $urandom;
    twd[p] = $urandom;
    tst[p] = 4'($urandom);
  endtask

  // Start of a cycle: retire/renew acked requests, random traffic when enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < 3; p++) begin
      if (rq[p] && ack_last[p]) begin
        if (!hold[p]) begin
          if (rand_mode && $urandom_range(1, 0) == 1) new_payload(p);
          else rq[p] = 1'b0;
        end
      end else if (rand_mode) begin
        if (!rq[p]) begin
          if ($urandom_range(3, 0) == 0) begin
            rq[p] = 1'b1;
            new_payload(p);
          end
        end else if (own_p == p && (cyc == own_arb + 1 || cyc == own_arb + 2)) begin
          new_payload(p);  // owner fiddles with payload; must be ignored
        end
      end
    end
  endtask

  // Reference model: one step per cycle, after inputs are final. An access
  // arbitrated in cycle c strobes memory at c+1, acks at c+2, frees at c+3.
  task automatic go();
    exp_t e;
    int   w;
    if (rst) begin
      while (mem_q.size() > 0 && mem_q[$].cyc >= cyc) void'(mem_q.pop_back());
      while (ack_q.size() > 0 && ack_q[$].cyc >= cyc) void'(ack_q.pop_back());
      age = 0;
      next_arb = cyc + 1;
      own_p = -1;
    end else if (cyc >= next_arb && (rq[0] || rq[1] || rq[2])) begin
      if (rq[0]) w = 0;
      else if (rq[2] && age >= AGE_LIMIT) w = 2;
      else if (rq[1]) w = 1;
      else w = 2;
      if (w == 2) age = 0;
      else if (rq[2]) age = (age + 1 > AGE_LIMIT) ? AGE_LIMIT : age + 1;
      e = '{cyc + 1, w, twe[w], tad[w], twd[w], tst[w]};
      mem_q.push_back(e);
      e.cyc = cyc + 2;
      ack_q.push_back(e);
      next_arb = cyc + 3;
      own_p = w;
      own_arb = cyc;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      go();
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   na;
    na = $countones(ack_v);
    for (int p = 0; p < 3; p++) ack_last[p] = ack_v[p];
    if (rst) begin
      last_we = 1'b0; last_addr = '0; last_wd = '0; last_st = '0;
    end
    while (mem_q.size() > 0 && mem_q[0].cyc < cyc) begin
      chk("mem_en_missing", 0, 1);
      void'(mem_q.pop_front());
    end
    while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
      chk("ack_missing", 0, 1);
      void'(ack_q.pop_front());
    end
    if (mem_en) begin
      gseq.push_back(grant_id);
      if (mem_q.size() == 0) chk("mem_en_unexpected", 1, 0);
      else begin
        e = mem_q.pop_front();
        chk("en_cycle", cyc, e.cyc);
        chk("en_grant", grant_id, e.port);
        chk("mem_we", mem_we, e.we);
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        chk("mem_wstrb", mem_wstrb, e.wstrb);
        chk("busy_issue", busy, 1);
        last_we = e.we; last_addr = e.addr; last_wd = e.wdata; last_st = e.wstrb;
      end
    end else begin
      if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
        chk("mem_en_missing", 0, 1);
        void'(mem_q.pop_front());
      end
      chk("hold_addr", mem_addr, last_addr);
      chk("hold_we_wd_st", {mem_we, mem_wdata, mem_wstrb}, {last_we, last_wd, last_st});
    end
    if (na > 1) chk("multi_ack", na, 1);
    for (int p = 0; p < 3; p++) begin
      if (ack_v[p]) begin
        if (p == 1) lsu_ack_cyc.push_back(cyc);
        if (ack_q.size() == 0) chk("ack_unexpected", p, 99);
        else begin
          e = ack_q.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_port", p, e.port);
          chk("ack_rdata", rdv[p], mem_rdata);
          chk("ack_grant", grant_id, p);
          chk("busy_wait", busy, 1);
        end
      end
    end
    if (na == 0 && ack_q.size() > 0 && ack_q[0].cyc == cyc) begin
      chk("ack_missing", 0, 1);
      void'(ack_q.pop_front());
    end
    if (!mem_en && na == 0) begin
      chk("grant_idle", grant_id, PORT_NONE);
      chk("busy_idle", busy, 0);
    end
  end

  initial begin
    int n;
    int exp_a[3];
    int exp_b[5];
    bit done;
    for (int p = 0; p < 3; p++) begin
      rq[p] = 0; twe[p] = 0; tad[p] = '0; twd[p] = '0; tst[p] = '0; hold[p] = 0;
    end

    // Reset with all three requesting; first arbitration when rst drops.
    tick(); rst = 1;
    for (int p = 0; p < 3; p++) begin rq[p] = 1; new_payload(p); end
    go();
    step(2);
    @(negedge clk);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, PORT_NONE);
    chk("rst_acks", ack_v, 3'b000);
    chk("rst_mem_bus", {mem_we, mem_addr, mem_wdata, mem_wstrb}, '0);
    gseq.delete();
    tick(); rst = 0; go();
    @(negedge clk);
    chk("first_arb_idle_grant", grant_id, PORT_NONE);
    step(10);
    exp_a = '{0, 1, 2};
    chk("order3_len", gseq.size(), 3);
    for (int i = 0; i < 3; i++) if (i < gseq.size()) chk("order3", gseq[i], exp_a[i]);

    // Single LSU read
    tick(); rq[1] = 1; twe[1] = 0; tad[1] = 32'h100; mem_rdata = 32'hDEADBEEF; go();
    tick(); go();
    @(negedge clk);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 32'h100);
    tick(); go();
    @(negedge clk);
    chk("rd_lsu_ack", lsu_if.ack, 1);
    chk("rd_lsu_rdata", lsu_if.rdata, 32'hDEADBEEF);
    step(2);

    // Single loader write
    tick(); rq[0] = 1; twe[0] = 1; tad[0] = 32'h0; twd[0] = 32'h13; tst[0] = 4'hF; go();
    tick(); go();
    @(negedge clk);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wstrb", mem_wstrb, 4'hF);
    chk("wr_mem_wdata", mem_wdata, 32'h13);
    tick(); go();
    @(negedge clk);
    chk("wr_ld_ack", ld_if.ack, 1);
    step(2);

    // LSU and fetch both held: fetch wins its 4th arbitration
    gseq.delete();
    tick(); rq[1] = 1; rq[2] = 1; hold[1] = 1; hold[2] = 1;
    twe[1] = 0; tad[1] = 32'h40; twe[2] = 0; tad[2] = 32'h80; go();
    step(14);
    tick(); hold[1] = 0; hold[2] = 0; go();
    step(12);
    exp_b = '{1, 1, 1, 2, 1};
    chk("aging_len_ok", gseq.size() >= 5, 1);
    for (int i = 0; i < 5; i++) if (i < gseq.size()) chk("aging_order", gseq[i], exp_b[i]);

    // Reset during WAIT aborts the access; LSU is regranted afterwards
    tick(); rq[1] = 1; twe[1] = 0; tad[1] = 32'h200; go();
    tick(); go();
    tick(); rst = 1; go();
    @(negedge clk);
    chk("abort_no_ack", lsu_if.ack, 0);
    tick(); rst = 0; go();
    @(negedge clk);
    chk("abort_mem_en", mem_en, 0);
    chk("abort_grant", grant_id, PORT_NONE);
    tick(); go();
    @(negedge clk);
    chk("rearb_mem_en", mem_en, 1);
    tick(); go();
    @(negedge clk);
    chk("rearb_ack", lsu_if.ack, 1);
    step(3);

    // Back-to-back: LSU request held nine cycles
    lsu_ack_cyc.delete();
    tick(); rq[1] = 1; hold[1] = 1; twe[1] = 1; tad[1] = 32'h300; twd[1] = 32'h55; tst[1] = 4'h3; go();
    n = cyc;
    step(8);
    tick(); hold[1] = 0; rq[1] = 0; go();
    step(4);
    chk("b2b_count", lsu_ack_cyc.size(), 3);
    for (int i = 0; i < 3; i++) if (i < lsu_ack_cyc.size()) chk("b2b_spacing", lsu_ack_cyc[i], n + 2 + 3 * i);

    // Randomized traffic with occasional reset pulses
    rand_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      mem_rdata = $urandom;
      rst = ($urandom_range(199, 0) == 0);
      go();
    end
    rand_mode = 0;
    tick(); rst = 0; go();
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick(); go();
      done = !(rq[0] || rq[1] || rq[2]) && mem_q.size() == 0 && ack_q.size() == 0;
    end
    chk("drain_done", done, 1);
    step(2);
    chk("sb_mem_empty", mem_q.size(), 0);
    chk("sb_ack_empty", ack_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
